// File: rtl/alu_pkg.sv
// Shared opcode encodings, default datapath width and FSM state type for the ALU pipeline.
package alu_pkg;

    localparam int DEFAULT_XLEN = 64;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low XLEN bits of the product.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] mcand_reg;
    logic [XLEN-1:0] mplier_reg;
    logic [XLEN-1:0] acc_reg;
    logic [XLEN-1:0] acc_next;
    logic [CW-1:0]   cnt_reg;
    logic            running_reg;

    assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
    // done and product are valid during the last step, so the caller can load them at that edge
    assign done     = running_reg && (cnt_reg == CW'(XLEN - 1));
    assign product  = acc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            running_reg <= 1'b0;
        end else if (abort) begin
            cnt_reg     <= '0;
            running_reg <= 1'b0;
        end else if (start) begin
            mcand_reg   <= a;
            mplier_reg  <= b;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            running_reg <= 1'b1;
        end else if (running_reg) begin
            acc_reg     <= acc_next;
            mcand_reg   <= mcand_reg << 1;
            mplier_reg  <= mplier_reg >> 1;
            cnt_reg     <= cnt_reg + CW'(1);
            if (done) begin
                running_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: single-cycle ops into one registered result stage, optional iterative multiply.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int XLEN   = DEFAULT_XLEN,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [3:0]      alu_ctrl,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            alu_zero,
    output logic            alu_ovf,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);

    state_t          state_reg;
    state_t          state_next;
    logic            out_valid_reg;
    logic [XLEN-1:0] result_reg;
    logic            zero_reg;
    logic            ovf_reg;

    logic            accept;
    logic            is_mul;
    logic            mul_start;
    logic            mul_done;
    logic [XLEN-1:0] mul_product;
    logic            load;
    logic [XLEN-1:0] load_result;
    logic            load_ovf;

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] op_result;
    logic            op_ovf;

    assign shamt = in2[SHW-1:0];
    assign sum   = in1 + in2;
    assign diff  = in1 - in2;

    always_comb begin
        op_result = '0;
        op_ovf    = 1'b0;
        case (alu_ctrl)
            OP_AND:  op_result = in1 & in2;
            OP_OR:   op_result = in1 | in2;
            OP_XOR:  op_result = in1 ^ in2;
            OP_ADD: begin
                op_result = sum;
                op_ovf    = (in1[XLEN-1] == in2[XLEN-1]) && (sum[XLEN-1] != in1[XLEN-1]);
            end
            OP_SUB: begin
                op_result = diff;
                op_ovf    = (in1[XLEN-1] != in2[XLEN-1]) && (diff[XLEN-1] != in1[XLEN-1]);
            end
            OP_SLL:  op_result = in1 << shamt;
            OP_SRL:  op_result = in1 >> shamt;
            OP_SRA:  op_result = XLEN'($signed(in1) >>> shamt);
            OP_SLT:  op_result = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
            OP_SLTU: op_result = {{(XLEN-1){1'b0}}, (in1 < in2)};
            // MUL (handled by the iterative unit) and unused codes produce zero here
            default: op_result = '0;
        endcase
    end

    assign is_mul    = MUL_EN && (alu_ctrl == OP_MUL);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && is_mul;

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_iter #(.XLEN(XLEN)) u_mul (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (mul_start),
                .abort   (flush),
                .a       (in1),
                .b       (in2),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    assign load        = !flush && ((accept && !is_mul) || ((state_reg == ST_MUL) && mul_done));
    assign load_result = (state_reg == ST_MUL) ? mul_product : op_result;
    assign load_ovf    = (state_reg == ST_MUL) ? 1'b0 : op_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (mul_start) state_next = ST_MUL;
            ST_MUL:  if (flush || mul_done) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_reg == ST_MUL);
        in_ready = (state_reg == ST_IDLE) && !flush && (!out_valid_reg || out_ready);
    end

    // flush drops the held result; a fresh load keeps out_valid high even when consumed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b1;
            ovf_reg       <= 1'b0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (load) begin
            out_valid_reg <= 1'b1;
            result_reg    <= load_result;
            zero_reg      <= (load_result == '0);
            ovf_reg       <= load_ovf;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid  = out_valid_reg;
    assign alu_result = result_reg;
    assign alu_zero   = zero_reg;
    assign alu_ovf    = ovf_reg;

endmodule
